canvas_arbiter: RTL

- Owns the single-port canvas RAM (one 3-bit color code per canvas pixel).
- Shares the RAM between VGA scan-out reads and brush/clear write commands from the MCU link. Scan reads always win.
- Feeds colorDecode the registered colorCode and a pixel-aligned brush-cursor overlay flag.
- Sits between the SPI command decoder, the VGA timing block and colorDecode.

---
 rtl/canvas_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/canvas_arbiter.sv
// Canvas RAM arbiter: scan-out reads always win the single RAM port.
// Brush stamps and canvas clears use the cycles that scan-out leaves free.
module canvas_arbiter #(
    parameter int          CANVAS_W   = 160,
    parameter int          CANVAS_H   = 120,
    parameter int          ADDR_W     = 15,
    parameter logic [2:0]  ERASE_CODE = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixEn,
    input  logic              vidActive,
    input  logic [7:0]        canvX,
    input  logic [6:0]        canvY,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdClear,
    input  logic [7:0]        cmdX,
    input  logic [6:0]        cmdY,
    input  logic [3:0]        cmdSize,
    input  logic [2:0]        cmdColor,
    input  logic [7:0]        cursorX,
    input  logic [6:0]        cursorY,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [2:0]        memWData,
    input  logic [2:0]        memRData,
    output logic [2:0]        colorCode,
    output logic              brush,
    output logic              busy,
    output logic [1:0]        dbgState
);

    // Command handshake: a command transfers in any cycle where cmdValid && cmdReady;
    // cmdValid is held by the producer until then and fields are sampled on that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic signed [9:0]  X_MAX     = 10'(CANVAS_W - 1);
    localparam logic signed [9:0]  Y_MAX     = 10'(CANVAS_H - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(y) * ADDR_W'(CANVAS_W) + ADDR_W'(x);
    endfunction

    state_t state;
    state_t stateNext;

    logic scan;
    logic accept;

    logic [7:0]        x0Q;
    logic [7:0]        x1Q;
    logic [6:0]        y1Q;
    logic [7:0]        curX;
    logic [6:0]        curY;
    logic [2:0]        colorQ;
    logic [ADDR_W-1:0] clrAddr;

    logic stampLast;
    logic clearLast;

    assign scan      = pixEn && vidActive;
    assign accept    = cmdValid && cmdReady;
    assign stampLast = (curX == x1Q) && (curY == y1Q);
    assign clearLast = (clrAddr == LAST_ADDR);
    assign dbgState  = state;

    // Clipped brush rectangle, computed signed so edges near 0 never wrap.
    logic signed [9:0] cx;
    logic signed [9:0] cy;
    logic signed [9:0] cs;
    logic signed [9:0] bx0;
    logic signed [9:0] bx1;
    logic signed [9:0] by0;
    logic signed [9:0] by1;
    logic              stampEmpty;

    always_comb begin
        cx  = $signed({2'b00, cmdX});
        cy  = $signed({3'b000, cmdY});
        cs  = $signed({6'b000000, cmdSize});
        bx0 = cx - cs;
        bx1 = cx + cs;
        by0 = cy - cs;
        by1 = cy + cs;
        if (bx0 < 0) begin
            bx0 = '0;
        end
        if (by0 < 0) begin
            by0 = '0;
        end
        if (bx1 > X_MAX) begin
            bx1 = X_MAX;
        end
        if (by1 > Y_MAX) begin
            by1 = Y_MAX;
        end
        stampEmpty = (bx0 > bx1) || (by0 > by1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cmdReady  = 1'b0;
        busy      = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWData  = '0;
        if (reset) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cmdReady = 1'b1;
                    if (cmdValid) begin
                        if (cmdClear) begin
                            stateNext = CLEAR;
                        end else if (!stampEmpty) begin
                            stateNext = STAMP;
                        end
                    end
                end
                STAMP: begin
                    busy = 1'b1;
                    if (!scan) begin
                        memWe    = 1'b1;
                        memAddr  = addr_of(curX, curY);
                        memWData = colorQ;
                        if (stampLast) begin
                            stateNext = IDLE;
                        end
                    end
                end
                CLEAR: begin
                    busy = 1'b1;
                    if (!scan) begin
                        memWe    = 1'b1;
                        memAddr  = clrAddr;
                        memWData = ERASE_CODE;
                        if (clearLast) begin
                            stateNext = IDLE;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
            // Scan slot owns the port; the pending write simply waits a cycle.
            if (scan) begin
                memAddr = addr_of(canvX, canvY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0Q     <= '0;
            x1Q     <= '0;
            y1Q     <= '0;
            curX    <= '0;
            curY    <= '0;
            colorQ  <= '0;
            clrAddr <= '0;
        end else if (accept) begin
            x0Q     <= bx0[7:0];
            x1Q     <= bx1[7:0];
            y1Q     <= by1[6:0];
            curX    <= bx0[7:0];
            curY    <= by0[6:0];
            colorQ  <= cmdColor;
            clrAddr <= '0;
        end else if (state == STAMP && !scan) begin
            if (curX == x1Q) begin
                curX <= x0Q;
                curY <= curY + 7'd1;
            end else begin
                curX <= curX + 8'd1;
            end
        end else if (state == CLEAR && !scan) begin
            clrAddr <= clrAddr + ADDR_W'(1);
        end
    end

    // Cursor outline hit for the current scan pixel.
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [8:0]        adx;
    logic [8:0]        ady;
    logic [8:0]        sz9;
    logic              hit;

    always_comb begin
        dx  = $signed({1'b0, canvX}) - $signed({1'b0, cursorX});
        dy  = $signed({2'b00, canvY}) - $signed({2'b00, cursorY});
        adx = dx[8] ? 9'(-dx) : 9'(dx);
        ady = dy[8] ? 9'(-dy) : 9'(dy);
        sz9 = {5'b00000, cmdSize};
        hit = (adx <= sz9) && (ady <= sz9) && ((adx == sz9) || (ady == sz9));
    end

    logic rdValid1;
    logic hit1;

    // Two-stage alignment: RAM data lands one cycle after the address, then is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdValid1  <= 1'b0;
            hit1      <= 1'b0;
            colorCode <= '0;
            brush     <= 1'b0;
        end else begin
            rdValid1 <= scan;
            hit1     <= scan && hit;
            brush    <= hit1;
            if (rdValid1) begin
                colorCode <= memRData;
            end
        end
    end

endmodule
